// File: rtl/regfile_commit_sched_pkg.sv
// Shared configuration for the commit scheduler: default sizes, state
// encoding and the head-pointer increment helper.
package regfile_commit_sched_pkg;

    localparam int QENTRIES_DEF = 8;
    localparam int RBIT_DEF     = 6;

    function automatic int qbits_f(input int n);
        return $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Queue pointers wrap modulo the queue depth.
    function automatic int head_add(input int h, input int n, input int q);
        return (h + n) % q;
    endfunction

endpackage

// File: rtl/regfile_commit_sched_commit_select.sv
// commit_select: combinational pick of up to two retiring queue entries.
// Ports: i_heads0/i_tail0 pointers, i_iq_* entry state; o_c0_*/o_c1_*
// commit slots, o_clr entries leaving the queue, o_adv head advance.
// NVIO_DUAL_COMMIT_EN enables the second slot (otherwise 1 advance max).
module commit_select
    import regfile_commit_sched_pkg::*;
#(
    parameter int QENTRIES = QENTRIES_DEF,
    parameter int RBIT     = RBIT_DEF,
    localparam int QBITS   = qbits_f(QENTRIES)
) (
    input  logic [QBITS-1:0]           i_heads0,
    input  logic [QBITS-1:0]           i_tail0,
    input  logic [QENTRIES-1:0]        i_iq_v,
    input  logic [QENTRIES-1:0]        i_iq_done,
    input  logic [QENTRIES-1:0]        i_iq_rfw,
    input  logic [QENTRIES-1:0][RBIT:0] i_iq_tgt,
    output logic                       o_c0_v,
    output logic [QBITS-1:0]           o_c0_id,
    output logic [RBIT:0]              o_c0_tgt,
    output logic                       o_c1_v,
    output logic [QBITS-1:0]           o_c1_id,
    output logic [RBIT:0]              o_c1_tgt,
    output logic [QENTRIES-1:0]        o_clr,
    output logic [1:0]                 o_adv
);

    logic w_h0_rdy;
    logic w_h0_skip;

    assign w_h0_rdy  = i_iq_v[i_heads0] & i_iq_done[i_heads0];
    // An invalid head is a hole only while the queue is non-empty.
    assign w_h0_skip = ~i_iq_v[i_heads0] & (i_heads0 != i_tail0);

`ifdef NVIO_DUAL_COMMIT_EN
    logic [QBITS-1:0] w_heads1;
    logic             w_h1_rdy;
    logic             w_wcoll;

    assign w_heads1 = QBITS'(head_add(int'(i_heads0), 1, QENTRIES));
    assign w_h1_rdy = i_iq_v[w_heads1] & i_iq_done[w_heads1];
    // Two writes to one register in a cycle are not allowed.
    assign w_wcoll  = i_iq_rfw[i_heads0] & i_iq_rfw[w_heads1]
                    & (i_iq_tgt[i_heads0] == i_iq_tgt[w_heads1]);
`endif

    always_comb begin
        o_c0_v   = 1'b0;
        o_c0_id  = '0;
        o_c0_tgt = '0;
        o_c1_v   = 1'b0;
        o_c1_id  = '0;
        o_c1_tgt = '0;
        o_clr    = '0;
        o_adv    = 2'd0;
        if (w_h0_rdy) begin
            o_c0_v   = 1'b1;
            o_c0_id  = i_heads0;
            o_c0_tgt = i_iq_rfw[i_heads0] ? i_iq_tgt[i_heads0] : '0;
            o_clr[i_heads0] = 1'b1;
            o_adv    = 2'd1;
        end else if (w_h0_skip) begin
            o_clr[i_heads0] = 1'b1;
            o_adv    = 2'd1;
        end
`ifdef NVIO_DUAL_COMMIT_EN
        if (w_h0_rdy && w_h1_rdy && !w_wcoll) begin
            o_c1_v   = 1'b1;
            o_c1_id  = w_heads1;
            o_c1_tgt = i_iq_rfw[w_heads1] ? i_iq_tgt[w_heads1] : '0;
            o_clr[w_heads1] = 1'b1;
            o_adv    = 2'd2;
        end else if (w_h0_skip && w_h1_rdy) begin
            // Skipped hole frees slot0 for the next entry.
            o_c0_v   = 1'b1;
            o_c0_id  = w_heads1;
            o_c0_tgt = i_iq_rfw[w_heads1] ? i_iq_tgt[w_heads1] : '0;
            o_clr[w_heads1] = 1'b1;
            o_adv    = 2'd2;
        end
`endif
    end

endmodule

// File: rtl/regfile_commit_sched.sv
// Register-file commit scheduler: RUN/FLUSH/HOLD control, head pointers
// and registered commit slots. Inputs: clk, rst, iq_* entry state, tail0,
// branchmiss, cmt_hold. Outputs: heads0/1, commit0/1 v/id/tgt, cmt_clr.
// NVIO_DUAL_COMMIT_EN enables dual commit in commit_select.
module regfile_commit_sched
    import regfile_commit_sched_pkg::*;
#(
    parameter int QENTRIES = QENTRIES_DEF,
    parameter int RBIT     = RBIT_DEF,
    localparam int QBITS   = qbits_f(QENTRIES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [QENTRIES-1:0]         iq_v,
    input  logic [QENTRIES-1:0]         iq_done,
    input  logic [QENTRIES-1:0]         iq_rfw,
    input  logic [QENTRIES-1:0][RBIT:0] iq_tgt,
    input  logic [QBITS-1:0]            tail0,
    input  logic                        branchmiss,
    input  logic                        cmt_hold,
    output logic [QBITS-1:0]            heads0,
    output logic [QBITS-1:0]            heads1,
    output logic                        commit0_v,
    output logic                        commit1_v,
    output logic [QBITS-1:0]            commit0_id,
    output logic [QBITS-1:0]            commit1_id,
    output logic [RBIT:0]               commit0_tgt,
    output logic [RBIT:0]               commit1_tgt,
    output logic [QENTRIES-1:0]         cmt_clr
);

    state_e               r_state;
    state_e               w_next;
    logic                 w_go;
    logic [QBITS-1:0]     r_heads0;
    logic                 r_c0_v, r_c1_v;
    logic [QBITS-1:0]     r_c0_id, r_c1_id;
    logic [RBIT:0]        r_c0_tgt, r_c1_tgt;
    logic [QENTRIES-1:0]  r_clr;

    logic                 w_c0_v, w_c1_v;
    logic [QBITS-1:0]     w_c0_id, w_c1_id;
    logic [RBIT:0]        w_c0_tgt, w_c1_tgt;
    logic [QENTRIES-1:0]  w_clr;
    logic [1:0]           w_adv;

    commit_select #(
        .QENTRIES (QENTRIES),
        .RBIT     (RBIT)
    ) u_sel (
        .i_heads0  (r_heads0),
        .i_tail0   (tail0),
        .i_iq_v    (iq_v),
        .i_iq_done (iq_done),
        .i_iq_rfw  (iq_rfw),
        .i_iq_tgt  (iq_tgt),
        .o_c0_v    (w_c0_v),
        .o_c0_id   (w_c0_id),
        .o_c0_tgt  (w_c0_tgt),
        .o_c1_v    (w_c1_v),
        .o_c1_id   (w_c1_id),
        .o_c1_tgt  (w_c1_tgt),
        .o_clr     (w_clr),
        .o_adv     (w_adv)
    );

    always_comb begin
        w_next = ST_RUN;
        case (r_state)
            ST_FLUSH: w_next = ST_RUN;
            ST_RUN, ST_HOLD: begin
                if (branchmiss)    w_next = ST_FLUSH;
                else if (cmt_hold) w_next = ST_HOLD;
                else               w_next = ST_RUN;
            end
            default:  w_next = ST_RUN;
        endcase
    end

    // Sample a selection only when the registered result lands in RUN,
    // so FLUSH and HOLD cycles always present an idle commit bus.
    assign w_go = (w_next == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_heads0 <= '0;
            r_c0_v   <= 1'b0;
            r_c0_id  <= '0;
            r_c0_tgt <= '0;
            r_c1_v   <= 1'b0;
            r_c1_id  <= '0;
            r_c1_tgt <= '0;
            r_clr    <= '0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_heads0 <= QBITS'(head_add(int'(r_heads0), int'(w_adv), QENTRIES));
                r_c0_v   <= w_c0_v;
                r_c0_id  <= w_c0_id;
                r_c0_tgt <= w_c0_tgt;
                r_c1_v   <= w_c1_v;
                r_c1_id  <= w_c1_id;
                r_c1_tgt <= w_c1_tgt;
                r_clr    <= w_clr;
            end else begin
                r_c0_v   <= 1'b0;
                r_c0_id  <= '0;
                r_c0_tgt <= '0;
                r_c1_v   <= 1'b0;
                r_c1_id  <= '0;
                r_c1_tgt <= '0;
                r_clr    <= '0;
            end
        end
    end

    assign heads0      = r_heads0;
    assign heads1      = QBITS'(head_add(int'(r_heads0), 1, QENTRIES));
    assign commit0_v   = r_c0_v;
    assign commit0_id  = r_c0_id;
    assign commit0_tgt = r_c0_tgt;
    assign commit1_v   = r_c1_v;
    assign commit1_id  = r_c1_id;
    assign commit1_tgt = r_c1_tgt;
    assign cmt_clr     = r_clr;

endmodule

// File: tb/tb_regfile_commit_sched.sv
// Self-checking bench for regfile_commit_sched: directed scenarios plus
// random traffic against a queue-walking reference model.
module tb_regfile_commit_sched;

    localparam int Q  = 8;
    localparam int RB = 6;
    localparam int QB = 3;
`ifdef NVIO_DUAL_COMMIT_EN
    localparam int LIM = 2;
`else
    localparam int LIM = 1;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [Q-1:0]          iq_v, iq_done, iq_rfw;
    logic [Q-1:0][RB:0]    iq_tgt;
    logic [QB-1:0]         tail0;
    logic                  branchmiss, cmt_hold;
    logic [QB-1:0]         heads0, heads1;
    logic                  commit0_v, commit1_v;
    logic [QB-1:0]         commit0_id, commit1_id;
    logic [RB:0]           commit0_tgt, commit1_tgt;
    logic [Q-1:0]          cmt_clr;

    int checks = 0;
    int failures = 0;

    // model: mode 0=run 1=flush 2=hold
    int m_head = 0;
    int m_mode = 0;
    logic          e_v0, e_v1;
    logic [QB-1:0] e_id0, e_id1;
    logic [RB:0]   e_t0, e_t1;
    logic [Q-1:0]  e_clr;

    always #5 clk = ~clk;

    regfile_commit_sched #(.QENTRIES(Q), .RBIT(RB)) dut (
        .clk(clk), .rst(rst),
        .iq_v(iq_v), .iq_done(iq_done), .iq_rfw(iq_rfw), .iq_tgt(iq_tgt),
        .tail0(tail0), .branchmiss(branchmiss), .cmt_hold(cmt_hold),
        .heads0(heads0), .heads1(heads1),
        .commit0_v(commit0_v), .commit1_v(commit1_v),
        .commit0_id(commit0_id), .commit1_id(commit1_id),
        .commit0_tgt(commit0_tgt), .commit1_tgt(commit1_tgt),
        .cmt_clr(cmt_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk the queue from the model head, retiring in order up to LIM
    // entries; the result is what must appear after the next edge.
    task automatic predict();
        int nm, adv, n, prev, idx;
        e_v0 = 0; e_v1 = 0; e_id0 = '0; e_id1 = '0;
        e_t0 = '0; e_t1 = '0; e_clr = '0;
        if (rst) begin
            m_head = 0;
            m_mode = 0;
            return;
        end
        if (m_mode == 1)     nm = 0;
        else if (branchmiss) nm = 1;
        else if (cmt_hold)   nm = 2;
        else                 nm = 0;
        adv = 0; n = 0; prev = 0;
        if (nm == 0) begin
            for (int k = 0; k < LIM; k++) begin
                idx = (m_head + k) % Q;
                if (iq_v[idx] && iq_done[idx]) begin
                    if (n == 1 && iq_rfw[idx] && iq_rfw[prev]
                        && iq_tgt[idx] == iq_tgt[prev]) break;
                    if (n == 0) begin
                        e_v0 = 1; e_id0 = QB'(idx);
                        e_t0 = iq_rfw[idx] ? iq_tgt[idx] : '0;
                    end else begin
                        e_v1 = 1; e_id1 = QB'(idx);
                        e_t1 = iq_rfw[idx] ? iq_tgt[idx] : '0;
                    end
                    n++; prev = idx; e_clr[idx] = 1'b1; adv++;
                end else if (!iq_v[idx] && k == 0 && idx != int'(tail0)) begin
                    e_clr[idx] = 1'b1; adv++;
                end else begin
                    break;
                end
            end
        end
        m_head = (m_head + adv) % Q;
        m_mode = nm;
    endtask

    task automatic cyc(input string tag);
        predict();
        @(posedge clk);
        #1;
        check({tag, ".heads0"}, 32'(heads0), 32'(m_head));
        check({tag, ".heads1"}, 32'(heads1), 32'((m_head + 1) % Q));
        check({tag, ".c0_v"}, 32'(commit0_v), 32'(e_v0));
        check({tag, ".c0_id"}, 32'(commit0_id), 32'(e_id0));
        check({tag, ".c0_tgt"}, 32'(commit0_tgt), 32'(e_t0));
        check({tag, ".c1_v"}, 32'(commit1_v), 32'(e_v1));
        check({tag, ".c1_id"}, 32'(commit1_id), 32'(e_id1));
        check({tag, ".c1_tgt"}, 32'(commit1_tgt), 32'(e_t1));
        check({tag, ".clr"}, 32'(cmt_clr), 32'(e_clr));
    endtask

    task automatic retire();
        iq_v = iq_v & ~e_clr;
    endtask

    task automatic clear_iq();
        iq_v = '0; iq_done = '0; iq_rfw = '0; iq_tgt = '0;
    endtask

    task automatic do_reset();
        rst = 1; branchmiss = 0; cmt_hold = 0; tail0 = '0;
        clear_iq();
        cyc("reset");
        rst = 0;
    endtask

    task automatic walk_to(input int h);
        int guard;
        clear_iq();
        tail0 = QB'(h);
        guard = 0;
        while (m_head != h && guard < 20) begin
            cyc("walk");
            guard++;
        end
        check("walk.reach", 32'(heads0), 32'(h));
    endtask

    logic [QB-1:0] hsave;

    initial begin
        do_reset();
        check("reset.heads1", 32'(heads1), 32'd1);
        check("reset.clr", 32'(cmt_clr), 32'd0);

        // single commit of entry 0 to r5
        iq_v[0] = 1; iq_done[0] = 1; iq_rfw[0] = 1; iq_tgt[0] = 7'd5;
        tail0 = 3'd1;
        cyc("r035");
        check("r035.v", 32'(commit0_v), 32'd1);
        check("r035.id", 32'(commit0_id), 32'd0);
        check("r035.tgt", 32'(commit0_tgt), 32'd5);
        check("r035.clr", 32'(cmt_clr), 32'h01);
        retire();
        cyc("empty");
        check("empty.v", 32'(commit0_v), 32'd0);

        // same-target collision
        do_reset();
        iq_v[1:0] = 2'b11; iq_done[1:0] = 2'b11; iq_rfw[1:0] = 2'b11;
        iq_tgt[0] = 7'd5; iq_tgt[1] = 7'd5; tail0 = 3'd2;
        cyc("r036a");
        check("r036a.c1v", 32'(commit1_v), 32'd0);
        check("r036a.id", 32'(commit0_id), 32'd0);
        retire();
        cyc("r036b");
        check("r036b.v", 32'(commit0_v), 32'd1);
        check("r036b.id", 32'(commit0_id), 32'd1);
        retire();

        // wraparound at 7 -> 0
        do_reset();
        walk_to(7);
        iq_v[7] = 1; iq_done[7] = 1; iq_rfw[7] = 1; iq_tgt[7] = 7'd3;
        iq_v[0] = 1; iq_done[0] = 1; iq_rfw[0] = 1; iq_tgt[0] = 7'd4;
        tail0 = 3'd1;
        cyc("r037");
`ifdef NVIO_DUAL_COMMIT_EN
        check("r037.clr", 32'(cmt_clr), 32'h81);
        check("r037.head", 32'(heads0), 32'd1);
        check("r037.c1id", 32'(commit1_id), 32'd0);
`else
        check("r037.clr", 32'(cmt_clr), 32'h80);
        check("r037.head", 32'(heads0), 32'd0);
`endif
        retire();
        cyc("r037b");
        retire();

        // branch miss flush
        do_reset();
        iq_v[3:0] = 4'hF; iq_done[3:0] = 4'hF; iq_rfw[3:0] = 4'hF;
        for (int i = 0; i < 4; i++) iq_tgt[i] = 7'(10 + i);
        tail0 = 3'd4;
        cyc("r038pre");
        retire();
        branchmiss = 1;
        cyc("r038bm");
        check("r038bm.v", 32'(commit0_v), 32'd0);
        branchmiss = 0;
        cyc("r038res");
        check("r038res.v", 32'(commit0_v), 32'd1);
        retire();

        // commit hold
        do_reset();
        iq_v[3:0] = 4'hF; iq_done[3:0] = 4'hF; iq_rfw[3:0] = 4'h0;
        tail0 = 3'd4;
        cmt_hold = 1;
        hsave = heads0;
        for (int i = 0; i < 3; i++) begin
            cyc("r039h");
            check("r039h.frozen", 32'(heads0), 32'(hsave));
            check("r039h.v", 32'(commit0_v), 32'd0);
        end
        cmt_hold = 0;
        cyc("r039rel");
        check("r039rel.v", 32'(commit0_v), 32'd1);
        check("r039rel.tgt", 32'(commit0_tgt), 32'd0);
        retire();

        // skip an invalid hole
        do_reset();
        walk_to(2);
        iq_v[3] = 1; iq_done[3] = 1; iq_rfw[3] = 1; iq_tgt[3] = 7'd9;
        tail0 = 3'd4;
        cyc("r040");
`ifdef NVIO_DUAL_COMMIT_EN
        check("r040.clr", 32'(cmt_clr), 32'h0C);
        check("r040.id", 32'(commit0_id), 32'd3);
`else
        check("r040.clr", 32'(cmt_clr), 32'h04);
        check("r040.v", 32'(commit0_v), 32'd0);
        retire();
        cyc("r040b");
        check("r040b.id", 32'(commit0_id), 32'd3);
        check("r040b.clr", 32'(cmt_clr), 32'h08);
`endif
        retire();

        // reset overrides branchmiss, and from mid-hold
        cmt_hold = 1;
        cyc("prehold");
        rst = 1; branchmiss = 1;
        cyc("rstbm");
        check("rstbm.head", 32'(heads0), 32'd0);
        rst = 0; branchmiss = 0; cmt_hold = 0;
        iq_v = '0; iq_v[0] = 1; iq_done[0] = 1; tail0 = 3'd1;
        cyc("afterrst");
        check("afterrst.v", 32'(commit0_v), 32'd1);
        retire();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            branchmiss = ($urandom_range(0, 9) == 0);
            cmt_hold = ($urandom_range(0, 7) == 0);
            iq_v = Q'($urandom);
            iq_done = Q'($urandom);
            iq_rfw = Q'($urandom);
            for (int i = 0; i < Q; i++) iq_tgt[i] = 7'($urandom_range(0, 3));
            tail0 = QB'($urandom);
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_commit_sched.md
REGFILE_COMMIT_SCHED -- requirements
Module: regfile_commit_sched

Interface
REQ-001 SHALL have parameter QENTRIES, default 8, queue depth (power of two, 4..16).
REQ-002 SHALL have parameter RBIT, default 6, MSB index of register target (AREGS = 2^(RBIT+1) = 128).
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port iq_v  input  QENTRIES  entry valid.
REQ-006 SHALL have port iq_done  input  QENTRIES  entry result ready.
REQ-007 SHALL have port iq_rfw  input  QENTRIES  entry writes register file.
REQ-008 SHALL have port iq_tgt  input  [RBIT:0] x QENTRIES  entry target register.
REQ-009 SHALL have port tail0  input  QBITS  queue insert pointer; QBITS = log2(QENTRIES).
REQ-010 SHALL have port branchmiss  input  1  pipeline flush request.
REQ-011 SHALL have port cmt_hold  input  1  external commit stall.
REQ-012 SHALL have ports heads0 and heads1  output  QBITS  oldest and second-oldest entry ids.
REQ-013 SHALL have ports commit0_v and commit1_v  output  1  commit slot valid.
REQ-014 SHALL have ports commit0_id and commit1_id  output  QBITS  committing entry id.
REQ-015 SHALL have ports commit0_tgt and commit1_tgt  output  [RBIT:0]  target register; zero when rfw is 0.
REQ-016 SHALL have port cmt_clr  output  QENTRIES  one-cycle pulse that clears iq_v of retired or skipped entries.

Function
REQ-017 SHALL implement FSM states RUN, FLUSH and HOLD.
REQ-018 RUN->FLUSH on branchmiss; FLUSH->RUN after exactly 1 cycle; RUN->HOLD on cmt_hold; HOLD->RUN when cmt_hold=0; branchmiss SHALL take priority over cmt_hold.
REQ-019 In RUN, slot0 SHALL commit when iq_v[heads0] and iq_done[heads0].
REQ-020 Slot1 SHALL commit only when slot0 commits and iq_v[heads1] and iq_done[heads1].
REQ-021 Slot1 SHALL be suppressed when both slots have rfw=1 and equal iq_tgt, so that no register sees two writes in one cycle.
REQ-022 An invalid entry at heads0 with heads0 != tail0 SHALL be skipped: the head advances and cmt_clr pulses for that entry; at most 2 advances per cycle combined.
REQ-023 The queue is empty when heads0 == tail0 and iq_v[heads0] = 0; when empty, no advance and commit_v = 0.
REQ-024 Commit outputs and cmt_clr SHALL be registered: 1-cycle latency from the iq_* sample.
REQ-025 heads0 SHALL advance by the count of committed plus skipped entries, modulo QENTRIES with wrap QENTRIES-1 -> 0, and heads1 SHALL equal heads0+1 modulo QENTRIES at all times.
REQ-026 In FLUSH and HOLD, commit*_v and cmt_clr SHALL be 0 and the heads SHALL not move.
REQ-027 In the branchmiss cycle itself, the selection registered from the prior cycle SHALL still be presented on the outputs.
REQ-028 Slot0 alone SHALL commit for an entry with iq_rfw = 0, and commit0_tgt SHALL be 0 in that case.

Reset
REQ-029 On rst: state=RUN, heads0=0, heads1=1, commit*_v=0, commit*_id=0, commit*_tgt=0, cmt_clr=0.
REQ-030 rst mid-FLUSH or mid-HOLD SHALL return the block to RUN in the next cycle with reset values, and rst SHALL override branchmiss.

Configuration
REQ-031 With macro NVIO_DUAL_COMMIT_EN defined, both slots SHALL operate.
REQ-032 Without NVIO_DUAL_COMMIT_EN, commit1_v SHALL be tied 0, heads0 SHALL advance at most 1 per cycle, and skipped entries SHALL count against that limit.

Structure
REQ-033 QBITS derivation, the FSM state enum (RUN/FLUSH/HOLD) and the head-increment function SHALL live in the shared config package alongside QENTRIES.
REQ-034 The combinational two-slot select (REQ-019..REQ-022) SHALL be a sub-module named commit_select, and the FSM and registers SHALL stay in the top module.

Verification
REQ-035 Reset, then heads0=0, iq_v[0]=iq_done[0]=1, iq_rfw[0]=1, iq_tgt[0]=5 -> next cycle commit0_v=1, commit0_id=0, commit0_tgt=5, cmt_clr=8'h01.
REQ-036 Entries 0 and 1 done with tgt 5 and 5, both rfw=1 -> only slot0 commits; the cycle after, entry 1 commits on slot0.
REQ-037 heads0=7 (QENTRIES=8), entries 7 and 0 done -> both commit, heads0 wraps to 1, cmt_clr=8'h81.
REQ-038 branchmiss pulsed for 1 cycle while entries are done -> one FLUSH cycle with commit*_v=0, then commits resume.
REQ-039 cmt_hold=1 for 3 cycles -> no commits and heads frozen; on release, commits resume next cycle.
REQ-040 Entry 2 invalid, heads0=2, tail0=4, entry 3 done -> entry 2 skipped, entry 3 commits on slot0, cmt_clr=8'h0C; repeat without NVIO_DUAL_COMMIT_EN -> skip only, entry 3 commits the following cycle.
